// File: rtl/hv_update_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | hv_update_ctrl : HV setpoint store and DAC update sequencer with retry and |
// |                  per-wait-state timeout supervision.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hv_update_ctrl #(
   parameter int MAX_RETRY = 3,
   parameter int TMO_CYC   = 1023
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        hv_req,
   input  logic        dac_idle,
   input  logic [2:0]  f_cnt,
   input  logic [7:0]  dac_err_reg,
   output logic        hv_start,
   output logic [15:0] dac_word,
   output logic        hv_busy,
   output logic        hv_done,
   output logic        hv_fail,
   output logic [7:0]  err_map,
   output logic [1:0]  retry_cnt,
   output logic        tmo_err,
   output logic        wr_rej
);

   localparam logic [9:0] c_TMO_CYC   = TMO_CYC[9:0];
   localparam logic [1:0] c_MAX_RETRY = MAX_RETRY[1:0];

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_CHECK     = 3'd4,
      S_FIN       = 3'd5
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_sp [8];
   logic [15:0] r_dac_word;
   logic [9:0]  r_tmo_cnt;
   logic [1:0]  r_retry;
   logic        r_fail;
   logic        r_tmo;
   logic [7:0]  r_err_map;
   logic        r_wr_rej;
   logic        w_busy;
   logic        w_tmo_hit;
   logic        w_in_wait;
   logic        w_accept;

   assign w_busy    = (r_state != S_IDLE);
   assign w_tmo_hit = (r_tmo_cnt == c_TMO_CYC);
   assign w_in_wait = (r_state == S_WAIT_BUSY) || (r_state == S_WAIT_DONE);
   assign w_accept  = (r_state == S_IDLE) && hv_req && dac_idle;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (hv_req && dac_idle) w_next = S_START;
         S_START:     w_next = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (!dac_idle)      w_next = S_WAIT_DONE;
            else if (w_tmo_hit) w_next = S_FIN;
         end
         S_WAIT_DONE: begin
            if (dac_idle)       w_next = S_CHECK;
            else if (w_tmo_hit) w_next = S_FIN;
         end
         S_CHECK: begin
            if (dac_err_reg == 8'h00)      w_next = S_FIN;
            else if (r_retry < c_MAX_RETRY) w_next = S_START;
            else                            w_next = S_FIN;
         end
         S_FIN:       w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Counter restarts on every state change so each wait state gets a full budget.
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset)                            r_tmo_cnt <= '0;
      else if (w_in_wait && w_next == r_state) r_tmo_cnt <= r_tmo_cnt + 10'd1;
      else                                   r_tmo_cnt <= '0;
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_retry   <= '0;
         r_fail    <= 1'b0;
         r_tmo     <= 1'b0;
         r_err_map <= '0;
      end else begin
         if (w_accept) begin
            r_retry   <= '0;
            r_fail    <= 1'b0;
            r_tmo     <= 1'b0;
            r_err_map <= '0;
         end
         if (w_in_wait && w_next == S_FIN) begin
            r_tmo  <= 1'b1;
            r_fail <= 1'b1;
         end
         if (r_state == S_CHECK) begin
            r_err_map <= dac_err_reg;
            if (dac_err_reg != 8'h00) begin
               if (r_retry < c_MAX_RETRY) r_retry <= r_retry + 2'd1;
               else                      r_fail  <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) r_sp[i] <= '0;
         r_dac_word <= '0;
         r_wr_rej   <= 1'b0;
      end else begin
         if (wr_en && !w_busy) r_sp[wr_addr] <= wr_data;
         r_dac_word <= r_sp[f_cnt];
         r_wr_rej   <= wr_en && w_busy;
      end
   end

   assign hv_start  = (r_state == S_START);
   assign hv_busy   = w_busy;
   assign hv_done   = (r_state == S_FIN);
   assign hv_fail   = r_fail;
   assign tmo_err   = r_tmo;
   assign err_map   = r_err_map;
   assign retry_cnt = r_retry;
   assign dac_word  = r_dac_word;
   assign wr_rej    = r_wr_rej;

endmodule
`default_nettype wire

// File: tb/tb_hv_update_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_hv_update_ctrl : directed bench with a small DAC sequencer model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_hv_update_ctrl;

   logic        CLK;
   logic        reset;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic        hv_req;
   logic        dac_idle;
   logic [2:0]  f_cnt;
   logic [7:0]  dac_err_reg;
   logic        hv_start;
   logic [15:0] dac_word;
   logic        hv_busy;
   logic        hv_done;
   logic        hv_fail;
   logic [7:0]  err_map;
   logic [1:0]  retry_cnt;
   logic        tmo_err;
   logic        wr_rej;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic        m_idle, m_active, tb_idle, m_hang, m_chk;
   logic [2:0]  m_fcnt, tb_fcnt;
   logic [7:0]  m_errs [4];
   int          m_len, m_attempt, start_cnt, start_cyc, m_lag_bad, done_cyc;
   logic [15:0] exp_sp [8];

   assign dac_idle = m_idle & tb_idle;
   assign f_cnt    = m_active ? m_fcnt : tb_fcnt;

   hv_update_ctrl #(.MAX_RETRY(3), .TMO_CYC(1023)) dut (
      .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .hv_req(hv_req), .dac_idle(dac_idle), .f_cnt(f_cnt), .dac_err_reg(dac_err_reg),
      .hv_start(hv_start), .dac_word(dac_word), .hv_busy(hv_busy), .hv_done(hv_done),
      .hv_fail(hv_fail), .err_map(err_map), .retry_cnt(retry_cnt), .tmo_err(tmo_err),
      .wr_rej(wr_rej)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // DAC sequencer model: on each hv_start it goes busy for m_len cycles, walking
   // f_cnt, then returns to idle presenting the error word for that attempt.
   initial begin
      m_idle = 1'b1; m_active = 1'b0; m_fcnt = '0; dac_err_reg = '0;
      forever begin
         @(negedge CLK);
         if (hv_start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
            if (!m_hang) begin
               m_active = 1'b1;
               m_idle   = 1'b0;
               for (int i = 0; i < m_len; i++) begin
                  m_fcnt = 3'(i);
                  @(negedge CLK);
                  if (m_chk && dac_word !== exp_sp[m_fcnt]) m_lag_bad = m_lag_bad + 1;
               end
               dac_err_reg = m_errs[(m_attempt > 3) ? 3 : m_attempt];
               m_attempt   = m_attempt + 1;
               m_idle      = 1'b1;
               m_active    = 1'b0;
            end
         end
      end
   end

   task automatic setup_model(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input int len, input logic hang, input logic chk);
      m_errs[0] = e0; m_errs[1] = e1; m_errs[2] = e2; m_errs[3] = e3;
      m_len = len; m_hang = hang; m_chk = chk;
      m_attempt = 0; start_cnt = 0; m_lag_bad = 0;
   endtask

   task automatic pulse_req(input logic we, input logic [2:0] a, input logic [15:0] d);
      @(negedge CLK);
      hv_req = 1'b1; wr_en = we; wr_addr = a; wr_data = d;
      @(negedge CLK);
      hv_req = 1'b0; wr_en = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if (hv_done) begin ok = 1'b1; done_cyc = cyc; end
         else @(negedge CLK);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(negedge CLK);
      checks++; if (hv_busy !== 1'b0 || hv_start !== 1'b0 || hv_done !== 1'b0) begin
         errors++; $display("FAIL rst_ctrl: busy/start/done=%b%b%b want 000", hv_busy, hv_start, hv_done); end
      checks++; if (hv_fail !== 1'b0 || tmo_err !== 1'b0 || wr_rej !== 1'b0) begin
         errors++; $display("FAIL rst_flags: fail/tmo/rej=%b%b%b want 000", hv_fail, tmo_err, wr_rej); end
      checks++; if (err_map !== 8'h00 || retry_cnt !== 2'd0 || dac_word !== 16'h0000) begin
         errors++; $display("FAIL rst_data: err_map=%h retry=%0d dac_word=%h want 00/0/0000", err_map, retry_cnt, dac_word); end
      reset = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_write;
      for (int n = 0; n < 8; n++) begin
         wr_en = 1'b1; wr_addr = 3'(n); wr_data = 16'h1000 + 16'(n);
         exp_sp[n] = 16'h1000 + 16'(n);
         @(negedge CLK);
      end
      wr_en = 1'b0;
      tb_fcnt = 3'd5; @(negedge CLK);
      checks++; if (dac_word !== 16'h1005) begin errors++; $display("FAIL wr_ch5: got %h want 1005", dac_word); end
      tb_fcnt = 3'd0; @(negedge CLK);
      checks++; if (dac_word !== 16'h1000) begin errors++; $display("FAIL wr_ch0: got %h want 1000", dac_word); end
      tb_fcnt = 3'd7; @(negedge CLK);
      checks++; if (dac_word !== 16'h1007) begin errors++; $display("FAIL wr_ch7: got %h want 1007", dac_word); end
   endtask

   task automatic test_drop;
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 10, 1'b0, 1'b1);
      tb_idle = 1'b0;
      pulse_req(1'b0, 3'd0, 16'h0);
      @(negedge CLK);
      checks++; if (hv_busy !== 1'b0 || start_cnt != 0) begin
         errors++; $display("FAIL drop: busy=%b starts=%0d want 0/0", hv_busy, start_cnt); end
      tb_idle = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_nominal;
      bit ok;
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 300, 1'b0, 1'b1);
      pulse_req(1'b0, 3'd0, 16'h0);
      checks++; if (hv_busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b want 1", hv_busy); end
      wait_done(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL nom_done: hv_done not seen, got 0 want 1"); end
      checks++; if (start_cnt != 1) begin errors++; $display("FAIL nom_starts: got %0d want 1", start_cnt); end
      checks++; if (hv_fail !== 1'b0 || retry_cnt !== 2'd0 || tmo_err !== 1'b0) begin
         errors++; $display("FAIL nom_status: fail=%b retry=%0d tmo=%b want 0/0/0", hv_fail, retry_cnt, tmo_err); end
      checks++; if (m_lag_bad != 0) begin errors++; $display("FAIL nom_lag: %0d bad dac_word samples want 0", m_lag_bad); end
      @(negedge CLK);
      checks++; if (hv_done !== 1'b0 || hv_busy !== 1'b0) begin
         errors++; $display("FAIL nom_pulse: done=%b busy=%b want 0/0", hv_done, hv_busy); end
   endtask

   task automatic test_retry;
      bit ok;
      setup_model(8'h04, 8'h04, 8'h00, 8'h00, 20, 1'b0, 1'b1);
      pulse_req(1'b0, 3'd0, 16'h0);
      wait_done(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rty_done: hv_done not seen, got 0 want 1"); end
      checks++; if (start_cnt != 3) begin errors++; $display("FAIL rty_starts: got %0d want 3", start_cnt); end
      checks++; if (retry_cnt !== 2'd2 || hv_fail !== 1'b0 || err_map !== 8'h00) begin
         errors++; $display("FAIL rty_status: retry=%0d fail=%b err_map=%h want 2/0/00", retry_cnt, hv_fail, err_map); end
      @(negedge CLK);
   endtask

   task automatic test_fail;
      bit ok;
      setup_model(8'h81, 8'h81, 8'h81, 8'h81, 20, 1'b0, 1'b1);
      pulse_req(1'b0, 3'd0, 16'h0);
      wait_done(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fl_done: hv_done not seen, got 0 want 1"); end
      checks++; if (start_cnt != 4) begin errors++; $display("FAIL fl_starts: got %0d want 4", start_cnt); end
      checks++; if (retry_cnt !== 2'd3 || hv_fail !== 1'b1 || err_map !== 8'h81 || tmo_err !== 1'b0) begin
         errors++; $display("FAIL fl_status: retry=%0d fail=%b err_map=%h tmo=%b want 3/1/81/0",
                            retry_cnt, hv_fail, err_map, tmo_err); end
      @(negedge CLK);
   endtask

   task automatic test_timeout;
      bit ok;
      int d;
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0);
      pulse_req(1'b0, 3'd0, 16'h0);
      wait_done(1200, ok);
      d = done_cyc - start_cyc;
      checks++; if (!ok) begin errors++; $display("FAIL tmo_done: hv_done not seen, got 0 want 1"); end
      checks++; if (d < 1023 || d > 1025) begin errors++; $display("FAIL tmo_delay: got %0d want 1024+-1", d); end
      checks++; if (tmo_err !== 1'b1 || hv_fail !== 1'b1 || start_cnt != 1) begin
         errors++; $display("FAIL tmo_status: tmo=%b fail=%b starts=%0d want 1/1/1", tmo_err, hv_fail, start_cnt); end
      m_hang = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_reject;
      bit ok;
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 300, 1'b0, 1'b1);
      pulse_req(1'b0, 3'd0, 16'h0);
      repeat (20) @(negedge CLK);
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
      @(negedge CLK);
      wr_en = 1'b0;
      checks++; if (wr_rej !== 1'b1) begin errors++; $display("FAIL rej_pulse: got %b want 1", wr_rej); end
      @(negedge CLK);
      checks++; if (wr_rej !== 1'b0) begin errors++; $display("FAIL rej_clear: got %b want 0", wr_rej); end
      wait_done(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rej_done: hv_done not seen, got 0 want 1"); end
      tb_fcnt = 3'd3;
      repeat (2) @(negedge CLK);
      checks++; if (dac_word !== 16'h1003) begin errors++; $display("FAIL rej_ch3: got %h want 1003", dac_word); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 10, 1'b0, 1'b1);
      exp_sp[5] = 16'h5555;
      pulse_req(1'b1, 3'd5, 16'h5555);
      checks++; if (hv_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", hv_busy); end
      wait_done(1000, ok);
      checks++; if (!ok || start_cnt != 1 || m_lag_bad != 0) begin
         errors++; $display("FAIL b2b_run: done=%b starts=%0d lag_bad=%0d want 1/1/0", ok, start_cnt, m_lag_bad); end
      tb_fcnt = 3'd5;
      repeat (2) @(negedge CLK);
      checks++; if (dac_word !== 16'h5555) begin errors++; $display("FAIL b2b_ch5: got %h want 5555", dac_word); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      bit saw_done;
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 300, 1'b0, 1'b0);
      pulse_req(1'b0, 3'd0, 16'h0);
      repeat (50) @(negedge CLK);
      checks++; if (hv_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", hv_busy); end
      reset = 1'b0;
      #1;
      checks++; if (hv_busy !== 1'b0 || hv_done !== 1'b0 || hv_start !== 1'b0 || hv_fail !== 1'b0 ||
                    tmo_err !== 1'b0 || wr_rej !== 1'b0 || err_map !== 8'h00 || retry_cnt !== 2'd0 ||
                    dac_word !== 16'h0000) begin
         errors++; $display("FAIL mid_rst: busy=%b done=%b start=%b fail=%b tmo=%b rej=%b map=%h rty=%0d word=%h want all 0",
                            hv_busy, hv_done, hv_start, hv_fail, tmo_err, wr_rej, err_map, retry_cnt, dac_word); end
      saw_done = 1'b0;
      repeat (5) begin @(negedge CLK); if (hv_done) saw_done = 1'b1; end
      reset = 1'b1;
      for (int i = 0; i < 600 && (m_active || i < 20); i++) begin
         @(negedge CLK);
         if (hv_done) saw_done = 1'b1;
      end
      checks++; if (saw_done || m_active) begin
         errors++; $display("FAIL mid_nodone: saw_done=%b model_active=%b want 0/0", saw_done, m_active); end
      tb_fcnt = 3'd1;
      repeat (2) @(negedge CLK);
      checks++; if (dac_word !== 16'h0000) begin errors++; $display("FAIL mid_sp: got %h want 0000", dac_word); end
      setup_model(8'h00, 8'h00, 8'h00, 8'h00, 20, 1'b0, 1'b0);
      pulse_req(1'b0, 3'd0, 16'h0);
      wait_done(1000, ok);
      checks++; if (!ok || start_cnt != 1 || hv_fail !== 1'b0 || retry_cnt !== 2'd0) begin
         errors++; $display("FAIL mid_clean: done=%b starts=%0d fail=%b retry=%0d want 1/1/0/0",
                            ok, start_cnt, hv_fail, retry_cnt); end
      @(negedge CLK);
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; hv_req = 1'b0;
      tb_idle = 1'b1; tb_fcnt = '0; m_hang = 1'b0; m_chk = 1'b0; m_len = 0;
      m_attempt = 0; start_cnt = 0; start_cyc = 0; m_lag_bad = 0; done_cyc = 0;
      for (int i = 0; i < 4; i++) m_errs[i] = '0;
      for (int i = 0; i < 8; i++) exp_sp[i] = '0;
      test_reset;
      test_write;
      test_drop;
      test_nominal;
      test_retry;
      test_fail;
      test_timeout;
      test_reject;
      test_back_to_back;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hv_update_ctrl.md
HV_UPDATE_CTRL -- requirements
Module: hv_update_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 3, max re-attempts after a failed update (range 0..3).
REQ-002 SHALL have parameter TMO_CYC, default 1023, cycles allowed in each wait state before timeout (10-bit).
REQ-003 SHALL have port CLK  in  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  in  1  host setpoint write strobe, one cycle.
REQ-006 SHALL have port wr_addr  in  3  target channel 0..7.
REQ-007 SHALL have port wr_data  in  16  channel HV DAC word.
REQ-008 SHALL have port hv_req  in  1  request an update of all 8 channels, one-cycle pulse.
REQ-009 SHALL have port dac_idle  in  1  high while the downstream DAC sequencer sits in its idle state.
REQ-010 SHALL have port f_cnt  in  3  frame index from the DAC sequencer.
REQ-011 SHALL have port dac_err_reg  in  8  per-frame error bits from the DAC sequencer.
REQ-012 SHALL have port hv_start  out  1  start pulse to the DAC sequencer.
REQ-013 SHALL have port dac_word  out  16  setpoint of channel f_cnt, registered.
REQ-014 SHALL have port hv_busy  out  1  update in progress.
REQ-015 SHALL have port hv_done  out  1  one-cycle pulse on completion, pass or fail.
REQ-016 SHALL have port hv_fail  out  1  sticky: last update ended with errors or a timeout.
REQ-017 SHALL have port err_map  out  8  dac_err_reg captured on the final attempt.
REQ-018 SHALL have port retry_cnt  out  2  re-attempts used by the last/current update.
REQ-019 SHALL have port tmo_err  out  1  sticky: last update ended on a timeout.
REQ-020 SHALL have port wr_rej  out  1  one-cycle pulse: a write was rejected.

Function
REQ-021 SHALL hold eight 16-bit setpoint registers; wr_en in IDLE writes wr_data to wr_addr on the same edge.
REQ-022 SHALL ignore wr_en while hv_busy=1 and pulse wr_rej the following cycle.
REQ-023 SHALL register dac_word <= setpoint[f_cnt] every cycle, giving 1-cycle latency from f_cnt.
REQ-024 SHALL implement states IDLE, START, WAIT_BUSY, WAIT_DONE, CHECK, FIN.
REQ-025 IDLE: on hv_req=1 and dac_idle=1 SHALL go to START, clear retry_cnt, hv_fail, tmo_err and err_map, and set hv_busy.
REQ-026 SHALL drop hv_req arriving in IDLE with dac_idle=0, with no state change.
REQ-027 START: SHALL assert hv_start for exactly one cycle, then go to WAIT_BUSY.
REQ-028 WAIT_BUSY: on dac_idle=0 SHALL go to WAIT_DONE; after TMO_CYC cycles SHALL set tmo_err and hv_fail and go to FIN.
REQ-029 WAIT_DONE: on dac_idle=1 SHALL go to CHECK; after TMO_CYC cycles SHALL set tmo_err and hv_fail and go to FIN.
REQ-030 SHALL clear the timeout counter on every wait-state entry; a timeout fires on the cycle the counter equals TMO_CYC.
REQ-031 CHECK: SHALL capture err_map <= dac_err_reg.
REQ-032 CHECK: if dac_err_reg==0, SHALL go to FIN with hv_fail=0.
REQ-033 CHECK: if dac_err_reg!=0 and retry_cnt<MAX_RETRY, SHALL increment retry_cnt and go to START.
REQ-034 CHECK: if dac_err_reg!=0 and retry_cnt==MAX_RETRY, SHALL set hv_fail and go to FIN.
REQ-035 FIN: SHALL pulse hv_done, clear hv_busy and return to IDLE in one cycle.
REQ-036 SHALL ignore hv_req in every state except IDLE.
REQ-037 SHALL give wr_en priority over hv_req when both arrive in IDLE on the same cycle: perform the write, then start the update.
REQ-038 SHALL keep retry_cnt saturating at MAX_RETRY, with no wrap.

Reset
REQ-039 While reset=0, SHALL force IDLE, all setpoints 16'h0000, and dac_word=0.
REQ-040 While reset=0, SHALL force hv_start, hv_busy, hv_done, hv_fail, tmo_err and wr_rej to 0, err_map=8'h00 and retry_cnt=0.
REQ-041 On reset asserted mid-update, SHALL abort immediately and emit no hv_done pulse.

Verification
REQ-042 Write ch0..7 = 16'h1000+n; hv_req; model holds dac_idle low 300 cycles, err=0 -> one hv_start, hv_done, hv_fail=0, retry_cnt=0, and dac_word tracks f_cnt with 1-cycle lag.
REQ-043 Model returns err=8'h04 twice, then 0 -> three hv_start pulses, retry_cnt=2, hv_fail=0, err_map=8'h00.
REQ-044 Model always returns err=8'h81 -> four hv_start pulses, retry_cnt=3, hv_fail=1, err_map=8'h81.
REQ-045 dac_idle never falls after hv_start -> hv_done 1024 cycles later (±1), tmo_err=1, hv_fail=1.
REQ-046 wr_en to ch3 during WAIT_DONE -> wr_rej pulse and ch3 value unchanged; same-cycle wr_en and hv_req in IDLE -> write lands and update starts.
REQ-047 Assert reset in WAIT_DONE -> all outputs at reset values, no hv_done; after release, hv_req starts a clean update.
